// File: rtl/stream_pkt_arb_pkg.sv
// Shared types and helpers for the packet-atomic weighted round-robin stream arbiter.
package stream_pkt_arb_pkg;

    typedef enum logic {
        ARB = 1'b0,
        PKT = 1'b1
    } arb_state_e;

    localparam int MaxSrc  = 32;
    localparam int MaxSrcW = 5;

    // Index of the first set bit of vec[n-1:0], scanning cyclically upward from start.
    function automatic int cyclic_first_set(logic [MaxSrc-1:0] vec, int n, int start);
        int idx;
        cyclic_first_set = start;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (start + k) % n;
            if (vec[idx[MaxSrcW-1:0]]) begin
                cyclic_first_set = idx;
            end
        end
    endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE=0 counts trailing zeros, MODE=1 leading zeros.
module lzc #(
    parameter int WIDTH    = 4,
    parameter int MODE     = 0,
    parameter int CntWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        if (MODE == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o = CntWidth'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) begin
                    cnt_o = CntWidth'(WIDTH - 1 - i);
                end
            end
        end
    end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-atomic weighted round-robin arbiter sharing one valid/ready sink between NumIn sources.
module stream_pkt_arbiter
    import stream_pkt_arb_pkg::*;
#(
    parameter int NumIn       = 4,
    parameter int DataWidth   = 32,
    parameter int WeightWidth = 4,
    parameter int IdxWidth    = $clog2(NumIn)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [NumIn*WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]             in_valid_i,
    output logic [NumIn-1:0]             in_ready_o,
    input  logic [NumIn*DataWidth-1:0]   in_data_i,
    input  logic [NumIn-1:0]             in_last_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DataWidth-1:0]         out_data_o,
    output logic                         out_last_o,
    output logic [IdxWidth-1:0]          out_idx_o,
    output logic                         busy_o
);

    localparam int CntW = WeightWidth + 1;

    arb_state_e             state_q, state_d;
    logic [IdxWidth-1:0]    owner_q, owner_d;
    logic [IdxWidth-1:0]    prio_q, prio_d;
    logic                   hold_q, hold_d;
    logic [WeightWidth-1:0] cnt_q, cnt_d;

    logic [DataWidth-1:0]   data_arr   [NumIn];
    logic [WeightWidth-1:0] weight_arr [NumIn];
    logic [NumIn-1:0]       upper_mask;
    logic [NumIn-1:0]       upper_req;
    logic [IdxWidth-1:0]    upper_idx, all_idx, search_idx, sel;
    logic                   upper_empty, all_empty;
    logic                   arb_free, valid_raw, hs;

    logic [WeightWidth-1:0] w_eff;
    logic [CntW-1:0]        next_cnt;
    logic [IdxWidth-1:0]    done_prio;
    logic [WeightWidth-1:0] done_cnt;

    always_comb begin
        for (int i = 0; i < NumIn; i++) begin
            data_arr[i]   = in_data_i[i*DataWidth +: DataWidth];
            weight_arr[i] = weight_i[i*WeightWidth +: WeightWidth];
            upper_mask[i] = (i >= int'(prio_q));
        end
    end

    // Cyclic search: first requester at or above prio_q, else first requester overall.
    assign upper_req = in_valid_i & upper_mask;

    lzc #(.WIDTH(NumIn), .MODE(0), .CntWidth(IdxWidth)) u_lzc_upper (
        .in_i    (upper_req),
        .cnt_o   (upper_idx),
        .empty_o (upper_empty)
    );

    lzc #(.WIDTH(NumIn), .MODE(0), .CntWidth(IdxWidth)) u_lzc_all (
        .in_i    (in_valid_i),
        .cnt_o   (all_idx),
        .empty_o (all_empty)
    );

    assign search_idx = upper_empty ? all_idx : upper_idx;
    assign arb_free   = (state_q == ARB) && !hold_q;
    assign sel        = arb_free ? search_idx : owner_q;
    assign valid_raw  = arb_free ? !all_empty : in_valid_i[sel];

    // Gating with rst_ni makes the handshake drop immediately on reset assertion.
    assign out_valid_o = rst_ni & valid_raw;
    assign hs          = out_valid_o & out_ready_i;
    assign out_data_o  = data_arr[sel];
    assign out_last_o  = in_last_i[sel];
    assign out_idx_o   = sel;
    assign busy_o      = (state_q == PKT);

    always_comb begin
        in_ready_o = '0;
        if (hs) begin
            in_ready_o[sel] = 1'b1;
        end
    end

    // Turn accounting at the end of a packet from sel; a zero weight counts as one.
    always_comb begin
        w_eff = (weight_arr[sel] == '0) ? WeightWidth'(1) : weight_arr[sel];
        if (sel != prio_q) begin
            next_cnt = CntW'(1);
        end else begin
            next_cnt = {1'b0, cnt_q} + CntW'(1);
        end
        if (next_cnt >= {1'b0, w_eff}) begin
            done_prio = (sel == IdxWidth'(NumIn - 1)) ? '0 : sel + IdxWidth'(1);
            done_cnt  = '0;
        end else begin
            done_prio = sel;
            done_cnt  = next_cnt[WeightWidth-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ARB;
            owner_d = '0;
            hold_d  = 1'b0;
            prio_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (out_valid_o && !out_ready_i) begin
                        hold_d  = 1'b1;
                        owner_d = sel;
                    end else if (hs && !out_last_o) begin
                        state_d = PKT;
                        owner_d = sel;
                        hold_d  = 1'b0;
                    end else if (hs) begin
                        owner_d = sel;
                        hold_d  = 1'b0;
                        prio_d  = done_prio;
                        cnt_d   = done_cnt;
                    end
                end
                PKT: begin
                    if (hs && out_last_o) begin
                        state_d = ARB;
                        prio_d  = done_prio;
                        cnt_d   = done_cnt;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            owner_q <= '0;
            hold_q  <= 1'b0;
            prio_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(in_ready_o));

    a_valid_kept : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i) |=> out_valid_o);

    a_idx_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_idx_o));

    a_search_ok : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (arb_free && !all_empty) |->
            (int'(search_idx) == cyclic_first_set(MaxSrc'(in_valid_i), NumIn, int'(prio_q))));
`endif

endmodule
